// File: rtl/capstone_pkg.sv
// Shared types and limits for the Capstone arithmetic datapath.
package capstone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CAPSTONE_MAX_WIDTH = 32;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - Bin, Bout set when the result borrows.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic Bin,
  output logic d,
  output logic Bout
);

  assign d    = x ^ y ^ Bin;
  assign Bout = (~x & y) | (~(x ^ y) & Bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A - B controller: walks one full_subtractor over WIDTH cycles, LSB
// first, with a start/busy/done handshake.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on the accepting edge
//   RUN   | one bit per cycle through u_fs, result shifts in from the MSB
//   DONE  | diff/bout freshly loaded, done pulses for this one cycle
module serial_subtractor_ctrl
  import capstone_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int             CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  generate
    if (WIDTH < 1 || WIDTH > CAPSTONE_MAX_WIDTH) begin : g_width_check
      $error("serial_subtractor_ctrl: WIDTH out of range");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_next;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             fs_d;
  logic             fs_bout;

  full_subtractor u_fs (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .Bin  (borrow),
    .d    (fs_d),
    .Bout (fs_bout)
  );

  // Widening before the shift keeps WIDTH=1 legal; the dropped MSB is always 0.
  assign r_next = WIDTH'({fs_d, r_sr} >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          r_sr   <= r_next;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= fs_bout;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            diff  <= r_next;
            bout  <= fs_bout;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl at WIDTH=8 and WIDTH=1; results go through
// per-instance queues that are drained whenever done is seen.
module tb_serial_subtractor_ctrl;

  typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] diff; logic bout; } vec8_t;
  typedef struct { logic a; logic b; logic diff; logic bout; } vec1_t;
  typedef struct { logic [7:0] diff; logic bout; } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start1, busy1, done1, bout1;
  logic [0:0] a1, b1, diff1;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb8[$];
  exp_t sb1[$];
  exp_t e8, e1;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboards: every done must match exactly one outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done8 === 1'b1) begin
      chk("done8_has_pending", 32'(sb8.size()), 1);
      if (sb8.size() != 0) begin
        e8 = sb8.pop_front();
        chk("diff8", diff8, e8.diff);
        chk("bout8", bout8, e8.bout);
      end
    end
    if (!rst && done1 === 1'b1) begin
      chk("done1_has_pending", 32'(sb1.size()), 1);
      if (sb1.size() != 0) begin
        e1 = sb1.pop_front();
        chk("diff1", diff1, e1.diff);
        chk("bout1", bout1, e1.bout);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle8();
    for (int i = 0; i < 20 && (busy8 !== 1'b0 || done8 !== 1'b0); i++) tick();
    chk("idle8_reached", {busy8, done8}, 0);
  endtask

  task automatic push8(input logic [7:0] ed, input logic eb);
    exp_t e;
    e.diff = ed;
    e.bout = eb;
    sb8.push_back(e);
  endtask

  task automatic run8(input logic [7:0] va, input logic [7:0] vb,
                      input logic [7:0] ed, input logic eb);
    int         busy_cnt;
    logic [7:0] hold_d;
    logic       hold_b;
    logic       stable;
    wait_idle8();
    a8 = va; b8 = vb; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    push8(ed, eb);
    busy_cnt = 0; hold_d = diff8; hold_b = bout8; stable = 1'b1;
    for (int i = 0; i < 20 && busy8 === 1'b1; i++) begin
      busy_cnt++;
      if (diff8 !== hold_d || bout8 !== hold_b) stable = 1'b0;
      tick();
    end
    chk("busy8_cycles", busy_cnt, 8);
    chk("done8_after_e8", done8, 1);
    chk("result_stable_in_run", stable, 1);
    tick();
    chk("done8_one_cycle", done8, 0);
  endtask

  vec8_t      vecs8[6];
  vec1_t      vecs1[4];
  logic [8:0] m;
  logic [7:0] ra, rb, x2a, x2b;
  int         seen;

  initial begin
    vecs8 = '{'{8'h5A, 8'h23, 8'h37, 1'b0},
              '{8'h00, 8'h01, 8'hFF, 1'b1},
              '{8'hFF, 8'hFF, 8'h00, 1'b0},
              '{8'h80, 8'h01, 8'h7F, 1'b0},
              '{8'h01, 8'h80, 8'h81, 1'b1},
              '{8'hFF, 8'h00, 8'hFF, 1'b0}};
    vecs1 = '{'{1'b0, 1'b0, 1'b0, 1'b0},
              '{1'b0, 1'b1, 1'b1, 1'b1},
              '{1'b1, 1'b0, 1'b1, 1'b0},
              '{1'b1, 1'b1, 1'b0, 1'b0}};

    // Reset held with start asserted and random operands
    rst = 1'b1; start8 = 1'b1; start1 = 1'b1;
    a8 = 8'($urandom); b8 = 8'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
    repeat (2) begin
      tick();
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_diff", diff8, 0);
      chk("rst_bout", bout8, 0);
      a8 = 8'($urandom); b8 = 8'($urandom);
    end
    rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
    tick();
    chk("idle_after_reset", {busy8, done8}, 0);

    foreach (vecs8[i]) run8(vecs8[i].a, vecs8[i].b, vecs8[i].diff, vecs8[i].bout);

    repeat (4) begin
      ra = 8'($urandom); rb = 8'($urandom);
      m  = {1'b0, ra} - {1'b0, rb};
      run8(ra, rb, m[7:0], m[8]);
    end

    // start held high through RUN and DONE while operands churn
    wait_idle8();
    ra = 8'($urandom); rb = 8'($urandom);
    x2a = 8'($urandom); x2b = 8'($urandom);
    a8 = ra; b8 = rb; start8 = 1'b1;
    tick();
    m = {1'b0, ra} - {1'b0, rb};
    push8(m[7:0], m[8]);
    for (int k = 1; k <= 10; k++) begin
      if (k < 10) begin a8 = 8'($urandom); b8 = 8'($urandom); end
      else begin a8 = x2a; b8 = x2b; end
      tick();
      if (k == 9) chk("idle_at_e9", {busy8, done8}, 0);
      if (k == 10) begin
        chk("accept_at_e10", busy8, 1);
        m = {1'b0, x2a} - {1'b0, x2b};
        push8(m[7:0], m[8]);
      end
    end
    start8 = 1'b0;
    for (int i = 0; i < 20 && done8 !== 1'b1; i++) tick();
    chk("second_op_done", done8, 1);
    tick();

    // Reset in the middle of a run
    run8(8'h10, 8'h01, 8'h0F, 1'b0);
    wait_idle8();
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    push8(8'h7F, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    sb8.delete();
    chk("midrst_busy", busy8, 0);
    chk("midrst_done", done8, 0);
    chk("midrst_diff", diff8, 0);
    chk("midrst_bout", bout8, 0);
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      tick();
      if (done8 !== 1'b0 || busy8 !== 1'b0) seen = 1;
    end
    chk("no_done_after_midrst", seen, 0);
    chk("diff_held_zero", diff8, 0);
    run8(8'h80, 8'h01, 8'h7F, 1'b0);

    // WIDTH=1 exhaustive
    foreach (vecs1[i]) begin
      a1 = vecs1[i].a; b1 = vecs1[i].b; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      e1.diff = {7'd0, vecs1[i].diff};
      e1.bout = vecs1[i].bout;
      sb1.push_back(e1);
      chk("w1_busy", {busy1, done1}, 2'b10);
      tick();
      chk("w1_done_after_e1", {busy1, done1}, 2'b01);
      tick();
      chk("w1_idle", {busy1, done1}, 2'b00);
    end

    repeat (3) tick();
    chk("sb8_drained", 32'(sb8.size()), 0);
    chk("sb1_drained", 32'(sb1.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial multi-bit subtractor controller. It computes the unsigned difference A − B with borrow-out by sequencing one existing `full_subtractor` instance over WIDTH clock cycles, LSB first. It sits in the Capstone arithmetic datapath as the area-minimal alternative to a WIDTH-wide ripple subtractor. It uses a start/busy/done handshake toward the requesting logic.

## Interface
- `WIDTH`, default 8: operand width in bits. Legal values are 1 to 32.
- `clk`  input  1: the single clock; all state changes on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `start`  input  1: request a subtraction. Sampled only in IDLE.
- `a`  input  WIDTH: minuend, captured on the accepting edge.
- `b`  input  WIDTH: subtrahend, captured on the accepting edge.
- `busy`  output  1: high while an operation is in progress (RUN state).
- `done`  output  1: one-cycle pulse when `diff` and `bout` are updated.
- `diff`  output  WIDTH: registered result (a − b) mod 2^WIDTH.
- `bout`  output  1: registered final borrow. It is 1 exactly when a < b, unsigned.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - With `start`=1 at an edge: load `a` into shift register `a_sr` and `b` into `b_sr`; clear `borrow`; clear `cnt`; go to RUN.
  - With `start`=0: stay in IDLE.
- **RUN**, at each edge:
  - `full_subtractor` inputs are x=`a_sr[0]`, y=`b_sr[0]`, Bin=`borrow`.
  - The d output shifts into the MSB of result register `r_sr`; `a_sr` and `b_sr` shift right.
  - `borrow` takes the Bout output, and `cnt` increments.
  - On the edge where `cnt` == WIDTH−1: load `diff` with the final shifted `r_sr` value (including this cycle's d) and load `bout` with this cycle's Bout; go to DONE.
- **DONE**: `done`=1 for this single cycle, then unconditionally back to IDLE. `start` seen in DONE is ignored and is not queued.
- `start` during RUN or DONE is ignored. Operands are not re-sampled.
- `a` and `b` may change freely after the accepting edge.
- `diff` and `bout` hold their last value until the next DONE or reset. They do not change during RUN.
- `busy` is 1 exactly in RUN. `done` is 1 exactly in DONE. Both are decoded from registered state, so there are no combinational paths from the inputs.
- Reset (any state, including mid-RUN): state becomes IDLE. `busy`=0, `done`=0, `diff`=0, `bout`=0. `a_sr`, `b_sr`, `r_sr`, `borrow` and `cnt` all become 0. The operation in progress is discarded and `done` is never issued for it.
- Reset has priority over `start` on the same edge.
- `cnt` width is $clog2(WIDTH)+1 bits, so WIDTH=1 is legal.
- WIDTH=1 behaviour: RUN lasts one cycle, giving `diff`=a^b and `bout`=~a&b.

## Timing
- Accepting edge E0 (IDLE, `start`=1). RUN occupies the cycles after E0 through E(WIDTH−1), so `busy` is high for WIDTH cycles.
- `diff` and `bout` update at edge E(WIDTH). `done` is high during the following cycle and drops at E(WIDTH+1).
- Latency is WIDTH edges from acceptance to results valid.
- Throughput: the earliest next accept is E(WIDTH+2), which means `start` must be high in IDLE. One operation takes WIDTH+2 cycles including IDLE.

## Structure
- Shared package `capstone_pkg`:
  - the state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the `CAPSTONE_MAX_WIDTH`=32 constant used by the WIDTH range check.
- Exactly one sub-module: the existing `full_subtractor` (ports x, y, Bin, d, Bout), instantiated once as `u_fs`. No other arithmetic is permitted; the borrow chain goes only through `u_fs`.
- A single always block covers state, counter and shift registers. Output decode is continuous assigns from state.

## Test plan
- **Reset:** hold `rst` for 2 cycles with random inputs and `start`=1. Required: `busy`=0, `done`=0, `diff`=0, `bout`=0 throughout; IDLE after release.
- **Basic subtraction (WIDTH=8):** a=8'h5A, b=8'h23, `start` pulsed at E0. Required: `busy` high for exactly 8 cycles; `done` for one cycle after E8; `diff`=8'h37, `bout`=0.
- **Borrow cases:** a=8'h00, b=8'h01 gives `diff`=8'hFF, `bout`=1. a=8'hFF, b=8'hFF gives `diff`=8'h00, `bout`=0.
- **Ignored start:** with `start` held high, change a/b every cycle during RUN and DONE. Required: the result equals the operands captured at E0 only; the next accept is at E10.
- **Reset mid-operation:** assert `rst` at E4 of a run with a=8'h80, b=8'h01. Required: no `done`, `diff`=0, `bout`=0. A following run with a=8'h80, b=8'h01 gives `diff`=8'h7F, `bout`=0.
- **WIDTH=1 exhaustive:** all four (a,b) combinations. Required: (`diff`,`bout`) matches the full_subtractor truth table with Bin=0; `done` one cycle after E1.
